// File: rtl/ppfifo_bram_dma.sv
// ppfifo_bram_dma: DMA engine between an internal true dual-port RAM and
// ping-pong FIFO buffers. Port A of the RAM is the user port; port B is
// driven by the transfer FSM for egress (memory -> PPFIFO) and ingress
// (PPFIFO -> memory) transfers. Read latency of both ports is MEM_WAIT clks.
// Optional feature macro: PPFIFO_BRAM_DMA_ADDR_WRAP_EN
//   defined   : transfer address wraps modulo 2**MEM_DEPTH, o_overflow stays 0
//   undefined : a transfer that hits the last address finishes that word and
//               completes early with o_overflow set
module ppfifo_bram_dma #(
  parameter int MEM_DEPTH  = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WAIT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_egr_stb,
  input  logic                  i_ing_stb,
  input  logic [MEM_DEPTH-1:0]  i_start_addr,
  input  logic                  i_abort,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [23:0]           o_xfer_count,
  output logic                  o_ing_has_data,
  output logic                  o_egr_is_ready,
  input  logic [1:0]            i_write_ready,
  output logic [1:0]            o_write_activate,
  input  logic [23:0]           i_write_size,
  output logic                  o_write_stb,
  output logic [DATA_WIDTH-1:0] o_write_data,
  input  logic                  i_read_ready,
  output logic                  o_read_activate,
  input  logic [23:0]           i_read_size,
  input  logic [DATA_WIDTH-1:0] i_read_data,
  output logic                  o_read_stb,
  input  logic                  i_mem_we,
  input  logic [MEM_DEPTH-1:0]  i_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_din,
  output logic [DATA_WIDTH-1:0] o_mem_dout
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    EGR_SETUP = 3'd1,
    EGR       = 3'd2,
    EGR_DRAIN = 3'd3,
    ING_SETUP = 3'd4,
    ING       = 3'd5,
    DONE      = 3'd6
  } state_t;

  localparam logic [MEM_DEPTH-1:0] ADDR_MAX = {MEM_DEPTH{1'b1}};
  localparam logic [MEM_DEPTH-1:0] ADDR_ONE = {{(MEM_DEPTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [MEM_DEPTH-1:0]  addr_q, addr_d;
  logic [23:0]           size_q, size_d;
  logic [23:0]           cnt_q, cnt_d;
  logic [23:0]           xfer_q, xfer_d;
  logic                  overflow_q, overflow_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic [1:0]            wact_q, wact_d;
  logic                  ract_q, ract_d;
  logic                  rstb_q, rstb_d;
  logic [MEM_WAIT-1:0]   vld_q, vld_d;
  logic                  rd_en_s;
  logic                  b_we_s;
  logic                  at_end_s;
  logic                  last_s;
  logic                  abort_s;

  logic [DATA_WIDTH-1:0] mem [0:(2**MEM_DEPTH)-1];
  logic [DATA_WIDTH-1:0] pipe_a_q [MEM_WAIT];
  logic [DATA_WIDTH-1:0] pipe_b_q [MEM_WAIT];

`ifdef PPFIFO_BRAM_DMA_ADDR_WRAP_EN
  assign at_end_s = 1'b0;
`else
  assign at_end_s = (addr_q == ADDR_MAX);
`endif

  assign last_s  = (cnt_q + 24'd1 == size_q);
  assign abort_s = i_abort && (state_q != IDLE);

  // Next-state, transfer bookkeeping and port-B control
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    cnt_d      = cnt_q;
    xfer_d     = xfer_q;
    overflow_d = overflow_q;
    wact_d     = wact_q;
    ract_d     = ract_q;
    rstb_d     = 1'b0;
    rd_en_s    = 1'b0;
    b_we_s     = 1'b0;
    if (vld_q[MEM_WAIT-1]) begin
      xfer_d = xfer_q + 24'd1;
    end else begin
      xfer_d = xfer_q;
    end
    case (state_q)
      IDLE: begin
        if (i_egr_stb || i_ing_stb) begin
          state_d    = i_egr_stb ? EGR_SETUP : ING_SETUP;
          addr_d     = i_start_addr;
          cnt_d      = 24'd0;
          xfer_d     = 24'd0;
          overflow_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      EGR_SETUP: begin
        if (i_write_ready != 2'b00) begin
          wact_d  = i_write_ready[0] ? 2'b01 : 2'b10;
          size_d  = i_write_size;
          state_d = EGR;
        end else begin
          state_d = EGR_SETUP;
        end
      end
      EGR: begin
        if (cnt_q < size_q) begin
          rd_en_s = 1'b1;
          addr_d  = addr_q + ADDR_ONE;
          cnt_d   = cnt_q + 24'd1;
          if (last_s || at_end_s) begin
            overflow_d = at_end_s && !last_s;
            state_d    = EGR_DRAIN;
          end else begin
            state_d = EGR;
          end
        end else begin
          state_d = EGR_DRAIN;
        end
      end
      EGR_DRAIN: begin
        // Only the word currently on the strobe may remain; anything younger
        // still has to come out before the buffer is handed back.
        if ((vld_q << 1) == {MEM_WAIT{1'b0}}) begin
          wact_d  = 2'b00;
          state_d = DONE;
        end else begin
          state_d = EGR_DRAIN;
        end
      end
      ING_SETUP: begin
        if (i_read_ready) begin
          ract_d  = 1'b1;
          size_d  = i_read_size;
          rstb_d  = (i_read_size != 24'd0);
          state_d = ING;
        end else begin
          state_d = ING_SETUP;
        end
      end
      ING: begin
        if (rstb_q) begin
          b_we_s = 1'b1;
          addr_d = addr_q + ADDR_ONE;
          cnt_d  = cnt_q + 24'd1;
          xfer_d = xfer_q + 24'd1;
          if (last_s || at_end_s) begin
            overflow_d = at_end_s && !last_s;
            ract_d     = 1'b0;
            state_d    = DONE;
          end else begin
            rstb_d  = 1'b1;
            state_d = ING;
          end
        end else begin
          ract_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort_s) begin
      state_d = IDLE;
      wact_d  = 2'b00;
      ract_d  = 1'b0;
      rstb_d  = 1'b0;
    end else begin
      state_d = state_d;
    end
    vld_d[0] = rd_en_s;
    for (int i = 1; i < MEM_WAIT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    if (abort_s) begin
      vld_d = {MEM_WAIT{1'b0}};
    end else begin
      vld_d = vld_d;
    end
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // Control and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= {MEM_DEPTH{1'b0}};
      size_q     <= 24'd0;
      cnt_q      <= 24'd0;
      xfer_q     <= 24'd0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      wact_q     <= 2'b00;
      ract_q     <= 1'b0;
      rstb_q     <= 1'b0;
      vld_q      <= {MEM_WAIT{1'b0}};
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      cnt_q      <= cnt_d;
      xfer_q     <= xfer_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      wact_q     <= wact_d;
      ract_q     <= ract_d;
      rstb_q     <= rstb_d;
      vld_q      <= vld_d;
    end
  end

  // Dual-port RAM with read pipelines; port B write is last so it wins a collision
  always_ff @(posedge clk) begin
    if (i_mem_we) begin
      mem[i_mem_addr] <= i_mem_din;
    end
    if (b_we_s) begin
      mem[addr_q] <= i_read_data;
    end
    pipe_a_q[0] <= mem[i_mem_addr];
    pipe_b_q[0] <= mem[addr_q];
    for (int i = 1; i < MEM_WAIT; i++) begin
      pipe_a_q[i] <= pipe_a_q[i-1];
      pipe_b_q[i] <= pipe_b_q[i-1];
    end
  end

  assign o_busy           = busy_q;
  assign o_done           = done_q;
  assign o_overflow       = overflow_q;
  assign o_xfer_count     = xfer_q;
  assign o_ing_has_data   = i_read_ready;
  assign o_egr_is_ready   = (i_write_ready != 2'b00);
  assign o_write_activate = wact_q;
  assign o_write_stb      = vld_q[MEM_WAIT-1];
  assign o_write_data     = pipe_b_q[MEM_WAIT-1];
  assign o_read_activate  = ract_q;
  assign o_read_stb       = rstb_q;
  assign o_mem_dout       = pipe_a_q[MEM_WAIT-1];

endmodule

// File: doc/ppfifo_bram_dma.md
PPFIFO_BRAM_DMA -- requirements
Module: ppfifo_bram_dma

Interface
REQ-001 Parameter MEM_DEPTH, default 10, SHALL set the memory address width (2**MEM_DEPTH words).
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the word width.
REQ-003 Parameter MEM_WAIT, default 2, legal 1..4, SHALL set the RAM read latency in clk cycles.
REQ-004 Ports SHALL be:
 clk  in  1  sole clock, all logic on rising edge
 rst  in  1  synchronous, active-high reset
 i_egr_stb  in  1  start a memory->PPFIFO transfer
 i_ing_stb  in  1  start a PPFIFO->memory transfer
 i_start_addr  in  MEM_DEPTH  first memory address, sampled on start
 i_abort  in  1  terminate the current transfer
 o_busy  out  1  high when not IDLE
 o_done  out  1  one-cycle pulse at normal completion
 o_overflow  out  1  sticky, transfer truncated at memory end
 o_xfer_count  out  24  words moved in the current or last transfer
 o_ing_has_data  out  1  equals i_read_ready
 o_egr_is_ready  out  1  high when i_write_ready != 0
 i_write_ready  in  2  egress PPFIFO buffer ready
 o_write_activate  out  2  egress buffer ownership
 i_write_size  in  24  egress buffer capacity
 o_write_stb  out  1  egress word strobe
 o_write_data  out  DATA_WIDTH  egress word
 i_read_ready  in  1  ingress PPFIFO buffer ready
 o_read_activate  out  1  ingress buffer ownership
 i_read_size  in  24  ingress buffer word count
 i_read_data  in  DATA_WIDTH  ingress head word
 o_read_stb  out  1  ingress pop strobe
 i_mem_we  in  1  user port write enable
 i_mem_addr  in  MEM_DEPTH  user port address
 i_mem_din  in  DATA_WIDTH  user port write data
 o_mem_dout  out  DATA_WIDTH  user port read data, MEM_WAIT latency

Function
REQ-005 Internal true dual-port RAM SHALL be used, both ports on clk; port A is the user port, port B is owned by the FSM.
REQ-006 FSM states SHALL be IDLE, EGR_SETUP, EGR, EGR_DRAIN, ING_SETUP, ING, DONE.
REQ-007 In IDLE: i_egr_stb -> EGR_SETUP; else i_ing_stb -> ING_SETUP; egress wins if both are asserted; on start, address <= i_start_addr, o_xfer_count <= 0, o_overflow <= 0.
REQ-008 EGR_SETUP SHALL wait for i_write_ready != 0 with o_write_activate == 0, assert bit 0 if ready[0] else bit 1, latch i_write_size, then go to EGR.
REQ-009 EGR SHALL issue one RAM read per cycle until the latched size is issued; o_write_stb/o_write_data SHALL assert exactly MEM_WAIT cycles after each read, one word per cycle with no gaps.
REQ-010 EGR_DRAIN SHALL wait for the last in-flight word, then release o_write_activate and go to DONE.
REQ-011 ING_SETUP SHALL wait for i_read_ready, assert o_read_activate, latch i_read_size, then go to ING.
REQ-012 In ING, each cycle with o_read_stb=1 SHALL write i_read_data to port B at the current address and increment the address; at most one pop per cycle, latched-size pops total; then release o_read_activate and go to DONE.
REQ-013 DONE SHALL pulse o_done for one cycle and return to IDLE.
REQ-014 o_xfer_count SHALL increment per o_write_stb or o_read_stb and hold until the next start.
REQ-015 Size 0 SHALL still activate and release the buffer, giving o_xfer_count=0 and an o_done pulse.
REQ-016 i_abort SHALL, in any non-IDLE state, drop both activates, discard in-flight egress words (no further o_write_stb), and go to IDLE the next cycle with no o_done pulse.
REQ-017 Start strobes SHALL be ignored while o_busy=1.
REQ-018 Simultaneous user-port and FSM writes to the same address SHALL leave the port-B data in memory.

Reset
REQ-019 On rst, state SHALL go to IDLE and the pipeline SHALL flush; o_write_activate=0, o_read_activate=0, o_write_stb=0, o_read_stb=0, o_done=0, o_overflow=0, o_xfer_count=0, o_busy=0; RAM contents are not cleared.
REQ-020 rst mid-transfer SHALL take priority over all other inputs, including i_abort.

Configuration
REQ-021 Macro PPFIFO_BRAM_DMA_ADDR_WRAP_EN defined: address SHALL wrap modulo 2**MEM_DEPTH, and o_overflow SHALL be tied 0.
REQ-022 Macro undefined: a transfer reaching address 2**MEM_DEPTH-1 SHALL finish that word and then stop as normal completion, setting o_overflow=1; egress issues no further reads, ingress pops no further words, and o_done pulses.

Verification
REQ-023 Ingress, start_addr=0x010, i_read_size=8, data 1..8 -> RAM[0x010..0x017]=1..8, o_xfer_count=8, one o_done.
REQ-024 Egress, start_addr=0x010, write_ready=2'b10, size=8 -> activate=2'b10, 8 contiguous strobes of 1..8, first MEM_WAIT cycles after the first read.
REQ-025 i_egr_stb and i_ing_stb in the same cycle -> egress runs, ingress ignored, o_read_activate stays 0.
REQ-026 Egress size=16, i_abort after 5 strobes -> activate drops, no further strobes, no o_done.
REQ-027 Ingress start_addr=0x3FE, size=4: with WRAP_EN -> words at 0x3FE,0x3FF,0x000,0x001; without -> 2 words written, o_overflow=1, o_xfer_count=2.
REQ-028 Size 0 transfer -> activate high for at least one cycle, o_done pulse, o_xfer_count=0.
